// File: rtl/uart_rx_frame_ctrl.sv
// Frame controller behind the UART byte receiver: hunts for a sync byte,
// captures length, payload and checksum, and holds a validated frame in a
// small buffer for the consumer until it is acknowledged.
module uart_rx_frame_ctrl #(
  parameter logic [7:0]  SYNC_BYTE      = 8'hA5,
  parameter int unsigned MAX_LEN        = 16,
  parameter int unsigned ADDR_W         = 4,
  parameter int unsigned TIMEOUT_CYCLES = 50000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rx_ready,
  input  logic [7:0]        rx_data,
  input  logic              frame_ack,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [7:0]        rd_data,
  output logic              frame_valid,
  output logic [7:0]        frame_len,
  output logic              err,
  output logic [1:0]        err_code
);

  localparam int unsigned DEPTH = 1 << ADDR_W;
  localparam int unsigned TMO_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

  localparam logic [1:0] ERR_LEN     = 2'd0;
  localparam logic [1:0] ERR_CSUM    = 2'd1;
  localparam logic [1:0] ERR_TIMEOUT = 2'd2;
  localparam logic [1:0] ERR_OVERRUN = 2'd3;

  typedef enum logic [2:0] {
    S_HUNT,
    S_LEN,
    S_PAYLOAD,
    S_CSUM,
    S_HOLD
  } state_t;

  state_t           state_q, state_d;
  logic [7:0]       len_d;
  logic [7:0]       sum_q, sum_d;
  logic [7:0]       idx_q, idx_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic             err_d;
  logic [1:0]       err_code_d;
  logic             valid_d;
  logic             wr_en_c;
  logic             in_frame_c;
  logic [7:0]       buffer [DEPTH];

  // Next-state, datapath and output decode
  always_comb begin
    state_d    = state_q;
    len_d      = frame_len;
    sum_d      = sum_q;
    idx_d      = idx_q;
    tmo_d      = '0;
    err_d      = 1'b0;
    err_code_d = err_code;
    wr_en_c    = 1'b0;
    in_frame_c = (state_q == S_LEN) || (state_q == S_PAYLOAD) || (state_q == S_CSUM);

    case (state_q)
      S_HUNT: begin
        if (rx_ready && (rx_data == SYNC_BYTE)) begin
          state_d = S_LEN;
        end
      end
      S_LEN: begin
        if (rx_ready) begin
          if ((rx_data == 8'd0) || (rx_data > 8'(MAX_LEN))) begin
            err_d      = 1'b1;
            err_code_d = ERR_LEN;
            state_d    = S_HUNT;
          end else begin
            len_d   = rx_data;
            sum_d   = rx_data;
            idx_d   = 8'd0;
            state_d = S_PAYLOAD;
          end
        end
      end
      S_PAYLOAD: begin
        if (rx_ready) begin
          wr_en_c = 1'b1;
          idx_d   = idx_q + 8'd1;
          sum_d   = sum_q + rx_data;
          if ((idx_q + 8'd1) == frame_len) begin
            state_d = S_CSUM;
          end
        end
      end
      S_CSUM: begin
        if (rx_ready) begin
          if (rx_data == sum_q) begin
            state_d = S_HOLD;
          end else begin
            err_d      = 1'b1;
            err_code_d = ERR_CSUM;
            state_d    = S_HUNT;
          end
        end
      end
      S_HOLD: begin
        if (rx_ready) begin
          err_d      = 1'b1;
          err_code_d = ERR_OVERRUN;
        end
        if (frame_ack) begin
          state_d = S_HUNT;
        end
      end
      default: begin
        state_d = S_HUNT;
      end
    endcase

    // Inter-byte watchdog; a byte on the expiry cycle wins over the timeout
    if (in_frame_c && !rx_ready) begin
      if (tmo_q == TMO_LAST) begin
        err_d      = 1'b1;
        err_code_d = ERR_TIMEOUT;
        state_d    = S_HUNT;
      end else begin
        tmo_d = tmo_q + TMO_W'(1);
      end
    end

    valid_d = (state_d == S_HOLD);
  end

  // State, counters and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_HUNT;
      frame_len   <= 8'd0;
      sum_q       <= 8'd0;
      idx_q       <= 8'd0;
      tmo_q       <= '0;
      err         <= 1'b0;
      err_code    <= 2'd0;
      frame_valid <= 1'b0;
    end else begin
      state_q     <= state_d;
      frame_len   <= len_d;
      sum_q       <= sum_d;
      idx_q       <= idx_d;
      tmo_q       <= tmo_d;
      err         <= err_d;
      err_code    <= err_code_d;
      frame_valid <= valid_d;
    end
  end

  // Payload buffer; written only while collecting payload so HOLD sees stable data
  always_ff @(posedge clk) begin
    if (wr_en_c) begin
      buffer[idx_q[ADDR_W-1:0]] <= rx_data;
    end
  end

  // Registered buffer read port
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data <= 8'd0;
    end else begin
      rd_data <= buffer[rd_addr];
    end
  end

endmodule

// File: tb/tb_uart_rx_frame_ctrl.sv
// Self-checking bench for uart_rx_frame_ctrl: directed frames followed by
// randomized byte traffic, compared every cycle against a queue-based model.
module tb_uart_rx_frame_ctrl;

  localparam int unsigned TMO  = 40;
  localparam int unsigned MAXL = 16;
  localparam int unsigned AW   = 4;
  localparam logic [7:0]  SYNC = 8'hA5;

  logic          clk = 1'b0;
  logic          rst;
  logic          rx_ready;
  logic [7:0]    rx_data;
  logic          frame_ack;
  logic [AW-1:0] rd_addr;
  logic [7:0]    rd_data;
  logic          frame_valid;
  logic [7:0]    frame_len;
  logic          err;
  logic [1:0]    err_code;

  int checks = 0;
  int errors = 0;

  uart_rx_frame_ctrl #(
    .SYNC_BYTE      (SYNC),
    .MAX_LEN        (MAXL),
    .ADDR_W         (AW),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .rx_ready    (rx_ready),
    .rx_data     (rx_data),
    .frame_ack   (frame_ack),
    .rd_addr     (rd_addr),
    .rd_data     (rd_data),
    .frame_valid (frame_valid),
    .frame_len   (frame_len),
    .err         (err),
    .err_code    (err_code)
  );

  always #5 clk = ~clk;

  // Reference model: bytes after sync are collected in a queue and judged
  // once enough have arrived to decide length or checksum.
  bit         m_in_frame;
  bit         m_hold;
  logic [7:0] m_q[$];
  int         m_idle;
  logic [7:0] m_len;
  logic       m_err;
  logic [1:0] m_code;
  logic [7:0] m_mem [16];
  bit         m_known [16];
  logic [7:0] m_rd;
  bit         m_rd_known;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_in_frame = 0;
    m_hold     = 0;
    m_q.delete();
    m_idle     = 0;
    m_len      = 8'd0;
    m_err      = 1'b0;
    m_code     = 2'd0;
    m_rd       = 8'd0;
    m_rd_known = 1;
    for (int i = 0; i < 16; i++) m_known[i] = 0;
  endfunction

  function automatic void raise(input logic [1:0] code);
    m_err  = 1'b1;
    m_code = code;
  endfunction

  function automatic void model_step(input logic rdy, input logic [7:0] d,
                                     input logic ack, input logic [AW-1:0] ra);
    int sum;
    m_rd_known = m_known[ra];
    m_rd       = m_mem[ra];
    m_err      = 1'b0;
    if (m_hold) begin
      if (rdy) raise(2'd3);
      if (ack) m_hold = 0;
    end else if (!m_in_frame) begin
      if (rdy && d == SYNC) begin
        m_in_frame = 1;
        m_q.delete();
        m_idle = 0;
      end
    end else if (rdy) begin
      m_idle = 0;
      m_q.push_back(d);
      if (m_q.size() == 1) begin
        if (d == 8'd0 || int'(d) > MAXL) begin
          raise(2'd0);
          m_in_frame = 0;
        end else begin
          m_len = d;
        end
      end else if (m_q.size() <= int'(m_q[0]) + 1) begin
        m_mem[m_q.size() - 2]   = d;
        m_known[m_q.size() - 2] = 1;
      end else begin
        sum = 0;
        for (int i = 0; i < m_q.size() - 1; i++) sum += int'(m_q[i]);
        if ((sum % 256) == int'(d)) m_hold = 1;
        else raise(2'd1);
        m_in_frame = 0;
      end
    end else begin
      m_idle++;
      if (m_idle == TMO) begin
        raise(2'd2);
        m_in_frame = 0;
      end
    end
  endfunction

  // One clock: drive inputs, advance model, sample outputs just after the edge
  task automatic cyc(input logic rdy, input logic [7:0] d, input logic ack,
                     input logic [AW-1:0] ra);
    rx_ready  = rdy;
    rx_data   = d;
    frame_ack = ack;
    rd_addr   = ra;
    model_step(rdy, d, ack, ra);
    @(posedge clk);
    #1;
    chk("err", 32'(err), 32'(m_err));
    chk("err_code", 32'(err_code), 32'(m_code));
    chk("frame_valid", 32'(frame_valid), 32'(m_hold));
    chk("frame_len", 32'(frame_len), 32'(m_len));
    if (m_rd_known) chk("rd_data", 32'(rd_data), 32'(m_rd));
    rx_ready  = 1'b0;
    frame_ack = 1'b0;
  endtask

  task automatic send(input logic [7:0] d);
    cyc(1'b1, d, 1'b0, AW'($urandom));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 8'($urandom), 1'b0, AW'($urandom));
  endtask

  task automatic ack();
    cyc(1'b0, 8'h00, 1'b1, AW'($urandom));
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    rx_ready  = 1'b0;
    frame_ack = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    chk("rst_err", 32'(err), 32'(0));
    chk("rst_err_code", 32'(err_code), 32'(0));
    chk("rst_valid", 32'(frame_valid), 32'(0));
    chk("rst_len", 32'(frame_len), 32'(0));
    chk("rst_rd_data", 32'(rd_data), 32'(0));
    rst = 1'b0;
  endtask

  // Random frame generator feeding a byte stream
  logic [7:0] sq[$];

  task automatic build_frame();
    int len;
    int sum;
    logic [7:0] b;
    if ($urandom_range(0, 4) == 0) sq.push_back(8'($urandom));
    sq.push_back(SYNC);
    case ($urandom_range(0, 9))
      0:       len = 0;
      1:       len = $urandom_range(17, 30);
      default: len = $urandom_range(1, 16);
    endcase
    sq.push_back(8'(len));
    if (len < 1 || len > 16) return;
    sum = len;
    for (int i = 0; i < len; i++) begin
      b = 8'($urandom);
      sum += int'(b);
      sq.push_back(b);
    end
    if ($urandom_range(0, 4) == 0) sq.push_back(8'(sum + 1));
    else sq.push_back(8'(sum));
  endtask

  initial begin
    logic rdy;
    logic ak;
    rst       = 1'b1;
    rx_ready  = 1'b0;
    rx_data   = 8'h00;
    frame_ack = 1'b0;
    rd_addr   = '0;
    do_reset();
    idle(2);

    // Good frame, read back, ack
    send(8'hA5); send(8'h03); send(8'h11); send(8'h22); send(8'h33); send(8'h69);
    cyc(1'b0, 8'h00, 1'b0, AW'(0));
    cyc(1'b0, 8'h00, 1'b0, AW'(1));
    cyc(1'b0, 8'h00, 1'b0, AW'(2));
    cyc(1'b0, 8'h00, 1'b0, AW'(3));
    chk("good_len", 32'(frame_len), 32'd3);
    ack();
    chk("good_acked", 32'(frame_valid), 32'd0);
    idle(2);

    // Bad checksum then a good frame
    send(8'hA5); send(8'h02); send(8'h10); send(8'h20); send(8'h00);
    send(8'hA5); send(8'h01); send(8'h7E); send(8'h7F);
    idle(1);
    ack();

    // Length errors, trailing bytes ignored in HUNT
    send(8'hA5); send(8'h00); send(8'h01); send(8'h02);
    send(8'hA5); send(8'h11); send(8'h01); send(8'h02);
    idle(2);

    // Timeout expiry, then byte landing exactly on the expiry cycle
    send(8'hA5); send(8'h04); send(8'h01);
    idle(TMO + 3);
    send(8'hA5); send(8'h04); send(8'h01);
    idle(TMO - 1);
    send(8'h02); send(8'h03); send(8'h04); send(8'h0E);
    chk("late_byte_valid", 32'(frame_valid), 32'd1);

    // Overrun while holding, then byte coincident with ack
    send(8'h55); send(8'h66); send(8'h77);
    cyc(1'b0, 8'h00, 1'b0, AW'(0));
    cyc(1'b0, 8'h00, 1'b0, AW'(3));
    cyc(1'b1, 8'hA5, 1'b1, AW'(1));
    send(8'hA5); send(8'h01); send(8'h33); send(8'h34);
    ack();
    // Back-to-back: sync right after ack cycle
    send(8'hA5); send(8'h01); send(8'h40); send(8'h41);
    ack();
    send(8'hA5); send(8'h01); send(8'h01); send(8'h02);
    ack();

    // Reset mid-payload, then wrap-around frames
    send(8'hA5); send(8'h04); send(8'h01); send(8'h02);
    do_reset();
    send(8'hA5); send(8'h02); send(8'hFF); send(8'hFF); send(8'hFF);
    send(8'hA5); send(8'h02); send(8'hFF); send(8'hFF); send(8'h00);
    cyc(1'b0, 8'h00, 1'b0, AW'(0));
    cyc(1'b0, 8'h00, 1'b0, AW'(1));
    ack();

    // Randomized traffic
    for (int n = 0; n < 4000; n++) begin
      if (sq.size() == 0) build_frame();
      if ($urandom_range(0, 299) == 0) idle(TMO - 2 + $urandom_range(0, 4));
      if (m_hold) rdy = ($urandom_range(0, 7) == 0);
      else rdy = ($urandom_range(0, 2) != 0);
      ak = ($urandom_range(0, 3) == 0);
      if (rdy) cyc(1'b1, sq.pop_front(), ak, AW'($urandom));
      else cyc(1'b0, 8'($urandom), ak, AW'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
